// File: rtl/lim_counter_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : lim_counter_chain_pkg
// Brief  : Shared state and direction encodings for the limited counter chain.
// Rev    : 1.0  initial release
// ============================================================================
package lim_counter_chain_pkg;

    // Run-control states of the counter chain
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Count direction as seen on the dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lim_digit.sv
`default_nettype none
// ============================================================================
// Module : lim_digit
// Brief  : One combinational modulo-L digit: step up/down with carry/borrow,
//          plus saturation of a preset digit to L-1.
// Rev    : 1.0  initial release
// ============================================================================
module lim_digit
    import lim_counter_chain_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_val,
    input  logic [W-1:0] i_lim,
    input  logic         i_ci,
    input  logic         i_dir,
    input  logic [W-1:0] i_load_digit,
    output logic [W-1:0] o_next,
    output logic         o_co,
    output logic [W-1:0] o_clamp
);

    // A limit of 2**W is encoded as 0 in W bits; subtracting 1 yields all ones,
    // so the largest legal digit value is correct for every supported limit.
    logic [W-1:0] w_max;
    assign w_max = i_lim - W'(1);

    // Step the digit by one in the selected direction when carry/borrow arrives
    always_comb begin
        o_next = i_val;
        o_co   = 1'b0;
        if (i_ci) begin
            case (i_dir)
                DIR_UP: begin
                    if (i_val == w_max) begin
                        o_next = '0;
                        o_co   = 1'b1;
                    end else begin
                        o_next = i_val + W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (i_val == '0) begin
                        o_next = w_max;
                        o_co   = 1'b1;
                    end else begin
                        o_next = i_val - W'(1);
                    end
                end
                default: begin
                    o_next = i_val;
                    o_co   = 1'b0;
                end
            endcase
        end
    end

    // Saturate an out-of-range preset digit to the largest legal value
    always_comb begin
        o_clamp = (i_load_digit > w_max) ? w_max : i_load_digit;
    end

endmodule
`default_nettype wire

// File: rtl/lim_counter_chain.sv
`default_nettype none
// ============================================================================
// Module : lim_counter_chain
// Brief  : Registered cascade of DIGITS limited counters with up/down mode,
//          run control, wrap-or-stop end of count, parallel load and a lap
//          (display freeze) register. Timebase of the stopwatch/countdown.
// Rev    : 1.0  initial release
// ============================================================================
module lim_counter_chain
    import lim_counter_chain_pkg::*;
#(
    parameter int                    DIGITS = 4,
    parameter int                    W      = 4,
    parameter logic [DIGITS*W-1:0]   LIMITS = {4'd6, 4'd10, 4'd6, 4'd10},
    parameter bit                    WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DIGITS*W-1:0]   load_val,
    input  logic                  dir,
    input  logic                  lap,
    output logic [DIGITS*W-1:0]   count,
    output logic [DIGITS*W-1:0]   disp,
    output logic                  running,
    output logic                  carry_out,
    output logic                  done
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIGITS*W-1:0]   r_count;
    logic [DIGITS*W-1:0]   w_count_nxt;
    logic [DIGITS*W-1:0]   r_disp;
    logic                  r_frozen;
    logic                  r_carry;
    logic                  w_carry_nxt;

    logic [DIGITS:0]       w_ci;
    logic [DIGITS*W-1:0]   w_step_val;
    logic [DIGITS*W-1:0]   w_clamp_val;
    logic                  w_step;
    logic                  w_term;

    // The least significant digit always receives the step
    assign w_ci[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            lim_digit #(
                .W (W)
            ) u_digit (
                .i_val        (r_count[gi*W +: W]),
                .i_lim        (LIMITS[gi*W +: W]),
                .i_ci         (w_ci[gi]),
                .i_dir        (dir),
                .i_load_digit (load_val[gi*W +: W]),
                .o_next       (w_step_val[gi*W +: W]),
                .o_co         (w_ci[gi+1]),
                .o_clamp      (w_clamp_val[gi*W +: W])
            );
        end
    endgenerate

    // Carry out of the top digit means every digit sat at its end value
    assign w_term = w_ci[DIGITS];
    assign w_step = (r_state == ST_RUNNING) && tick;

    // Next state: clear/load force STOPPED; a terminal tick without wrap ends in DONE
    always_comb begin
        w_state_nxt = r_state;
        if (clear || load) begin
            w_state_nxt = ST_STOPPED;
        end else begin
            case (r_state)
                ST_STOPPED: if (start && !stop) w_state_nxt = ST_RUNNING;
                ST_RUNNING: begin
                    if (tick && w_term && (WRAP == 1'b0)) begin
                        w_state_nxt = ST_DONE;
                    end else if (stop) begin
                        w_state_nxt = ST_STOPPED;
                    end
                end
                ST_DONE:    w_state_nxt = ST_DONE;
                default:    w_state_nxt = ST_STOPPED;
            endcase
        end
    end

    // Next count and wrap pulse: clear beats load beats a step
    always_comb begin
        w_count_nxt = r_count;
        w_carry_nxt = 1'b0;
        if (clear) begin
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = w_clamp_val;
        end else if (w_step) begin
            if (!(w_term && (WRAP == 1'b0))) begin
                w_count_nxt = w_step_val;
                w_carry_nxt = w_term;
            end
        end
    end

    // State, count and wrap-pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STOPPED;
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    // Display follows count one cycle behind unless frozen; any lap reloads it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp   <= '0;
            r_frozen <= 1'b0;
        end else begin
            if (lap || !r_frozen) begin
                r_disp <= r_count;
            end
            r_frozen <= clear ? 1'b0 : (r_frozen ^ lap);
        end
    end

    assign count     = r_count;
    assign disp      = r_disp;
    assign running   = (r_state == ST_RUNNING);
    assign done      = (r_state == ST_DONE);
    assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_lim_counter_chain.sv
`default_nettype none
// ============================================================================
// Module : tb_lim_counter_chain
// Brief  : Scoreboard bench for lim_counter_chain; one wrapping and one
//          stopping instance share the stimulus and a mixed-radix model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lim_counter_chain;

    localparam int LIM [4] = '{10, 6, 10, 6};   // digit 0 first
    localparam int NTOT    = 3600;

    typedef struct packed {
        logic [15:0] cnt_w;
        logic [15:0] disp_w;
        logic        run_w;
        logic        cy_w;
        logic        dn_w;
        logic [15:0] cnt_h;
        logic [15:0] disp_h;
        logic        run_h;
        logic        cy_h;
        logic        dn_h;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick, start, stop, clear, load, dir, lap;
    logic [15:0] load_val;
    logic [15:0] cnt_w, disp_w, cnt_h, disp_h;
    logic        run_w, cy_w, dn_w, run_h, cy_h, dn_h;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q_exp[$];

    // model state, index 0 = wrapping instance, 1 = stopping instance
    logic [15:0] m_cnt [2];
    logic [15:0] m_disp[2];
    bit          m_frz [2];
    int          m_st  [2];   // 0 stopped, 1 running, 2 done
    bit          m_cy  [2];

    always #5 clk = ~clk;

    lim_counter_chain #(.DIGITS(4), .W(4), .LIMITS({4'd6, 4'd10, 4'd6, 4'd10}), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val), .dir(dir), .lap(lap),
        .count(cnt_w), .disp(disp_w), .running(run_w), .carry_out(cy_w), .done(dn_w)
    );

    lim_counter_chain #(.DIGITS(4), .W(4), .LIMITS({4'd6, 4'd10, 4'd6, 4'd10}), .WRAP(1'b0)) u_hold (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val), .dir(dir), .lap(lap),
        .count(cnt_h), .disp(disp_h), .running(run_h), .carry_out(cy_h), .done(dn_h)
    );

    function automatic int to_val(input logic [15:0] x);
        int v = 0;
        int wt = 1;
        for (int i = 0; i < 4; i++) begin
            v  += int'(x[i*4 +: 4]) * wt;
            wt *= LIM[i];
        end
        return v;
    endfunction

    function automatic logic [15:0] from_val(input int v);
        logic [15:0] x = '0;
        int r = v;
        for (int i = 0; i < 4; i++) begin
            x[i*4 +: 4] = 4'(r % LIM[i]);
            r = r / LIM[i];
        end
        return x;
    endfunction

    function automatic logic [15:0] clampv(input logic [15:0] x);
        logic [15:0] y = '0;
        for (int i = 0; i < 4; i++) begin
            y[i*4 +: 4] = (int'(x[i*4 +: 4]) > LIM[i] - 1) ? 4'(LIM[i] - 1) : x[i*4 +: 4];
        end
        return y;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = '0; m_disp[k] = '0; m_frz[k] = 0; m_st[k] = 0; m_cy[k] = 0;
        end
    endtask

    task automatic model_step(input bit t, s, p, c, l, input logic [15:0] lv, input bit d, input bit lp);
        for (int k = 0; k < 2; k++) begin
            bit wrap = (k == 0);
            int v;
            int nst;
            bit term;
            if (lp || !m_frz[k]) m_disp[k] = m_cnt[k];
            m_frz[k] = c ? 1'b0 : (m_frz[k] ^ lp);
            m_cy[k]  = 0;
            if (c) begin
                m_cnt[k] = '0; m_st[k] = 0;
            end else if (l) begin
                m_cnt[k] = clampv(lv); m_st[k] = 0;
            end else begin
                nst = m_st[k];
                if (m_st[k] == 0 && s && !p) nst = 1;
                if (m_st[k] == 1 && p) nst = 0;
                if (m_st[k] == 1 && t) begin
                    v    = to_val(m_cnt[k]);
                    term = d ? (v == 0) : (v == NTOT - 1);
                    if (term && !wrap) nst = 2;
                    else if (term) begin
                        m_cnt[k] = from_val(d ? NTOT - 1 : 0);
                        m_cy[k]  = 1;
                    end else m_cnt[k] = from_val(d ? v - 1 : v + 1);
                end
                m_st[k] = nst;
            end
        end
    endtask

    // Drive one cycle of inputs at a falling edge, queue the expected result,
    // and return at the next falling edge after the design has clocked them.
    task automatic cyc(input bit t, s, p, c, l, input logic [15:0] lv, input bit d, input bit lp);
        exp_t e;
        tick = t; start = s; stop = p; clear = c; load = l; load_val = lv; dir = d; lap = lp;
        model_step(t, s, p, c, l, lv, d, lp);
        e.cnt_w = m_cnt[0]; e.disp_w = m_disp[0]; e.run_w = (m_st[0] == 1);
        e.cy_w  = m_cy[0];  e.dn_w   = (m_st[0] == 2);
        e.cnt_h = m_cnt[1]; e.disp_h = m_disp[1]; e.run_h = (m_st[1] == 1);
        e.cy_h  = m_cy[1];  e.dn_h   = (m_st[1] == 2);
        q_exp.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    // Monitor: compare every queued expectation just after the edge it belongs to
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            cmp("count_wrap",   cnt_w,         e.cnt_w);
            cmp("disp_wrap",    disp_w,        e.disp_w);
            cmp("running_wrap", {15'd0, run_w}, {15'd0, e.run_w});
            cmp("carry_wrap",   {15'd0, cy_w},  {15'd0, e.cy_w});
            cmp("done_wrap",    {15'd0, dn_w},  {15'd0, e.dn_w});
            cmp("count_hold",   cnt_h,         e.cnt_h);
            cmp("disp_hold",    disp_h,        e.disp_h);
            cmp("running_hold", {15'd0, run_h}, {15'd0, e.run_h});
            cmp("carry_hold",   {15'd0, cy_h},  {15'd0, e.cy_h});
            cmp("done_hold",    {15'd0, dn_h},  {15'd0, e.dn_h});
        end
    end

    initial begin
        bit rd;
        reset_n = 1'b0;
        tick = 0; start = 0; stop = 0; clear = 0; load = 0; load_val = '0; dir = 0; lap = 0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset_count",   cnt_w, 16'h0000);
        cmp("reset_disp",    disp_h, 16'h0000);
        cmp("reset_running", {14'd0, run_w, run_h}, 16'h0);
        cmp("reset_flags",   {12'd0, cy_w, cy_h, dn_w, dn_h}, 16'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // cascade through two digits
        cyc(0, 0, 0, 0, 1, 16'h0959, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("cascade_count", cnt_w, 16'h1000);
        cmp("cascade_carry", {15'd0, cy_w}, 16'h0);

        // top end: wrap vs stop
        cyc(0, 0, 0, 0, 1, 16'h5959, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("top_wrap_count", cnt_w, 16'h0000);
        cmp("top_wrap_carry", {15'd0, cy_w}, 16'h1);
        cmp("top_hold_count", cnt_h, 16'h5959);
        cmp("top_hold_done",  {15'd0, dn_h}, 16'h1);
        idle();
        cmp("top_carry_one_cycle", {15'd0, cy_w}, 16'h0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 1, 0, 0, 0, 16'h0, 0, 0);
        cmp("done_sticky_count", cnt_h, 16'h5959);
        cmp("done_sticky_flags", {14'd0, dn_h, run_h}, 16'h2);

        // down counting with borrow and bottom end
        cyc(0, 0, 0, 0, 1, 16'h0100, 1, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 1, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 1, 0);
        cmp("down_borrow", cnt_w, 16'h0059);
        cyc(0, 0, 0, 0, 1, 16'h0000, 1, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 1, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 1, 0);
        cmp("down_hold_done",  {15'd0, dn_h}, 16'h1);
        cmp("down_hold_count", cnt_h, 16'h0000);
        cmp("down_wrap_count", cnt_w, 16'h5959);

        // lap freeze and release
        cyc(0, 0, 0, 1, 0, 16'h0, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("lap_pre_count", cnt_w, 16'h0012);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 1);
        repeat (7) cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("lap_frozen_disp",  disp_w, 16'h0012);
        cmp("lap_frozen_count", cnt_w, 16'h0020);
        cyc(0, 0, 0, 0, 0, 16'h0, 0, 1);
        cmp("lap_release_disp", disp_w, 16'h0020);

        // clamp, then clear beats load and tick and unfreezes
        cyc(0, 0, 0, 0, 1, 16'h0F7C, 0, 0);
        cmp("clamp_count", cnt_w, 16'h0959);
        cyc(0, 0, 0, 0, 0, 16'h0, 0, 1);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("freeze_disp", disp_w, 16'h0959);
        cyc(1, 0, 0, 1, 1, 16'h1234, 0, 0);
        cmp("prio_count",   cnt_w, 16'h0000);
        cmp("prio_running", {15'd0, run_w}, 16'h0);
        idle();
        cmp("prio_unfrozen_disp", disp_w, 16'h0000);

        // asynchronous reset mid-run
        cyc(0, 0, 0, 0, 1, 16'h0346, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 0, 0);
        cmp("async_pre_count", cnt_w, 16'h0347);
        tick = 0; start = 0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async_count",   cnt_w, 16'h0000);
        cmp("async_disp",    disp_w, 16'h0000);
        cmp("async_running", {15'd0, run_w}, 16'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic
        rd = 0;
        for (int n = 0; n < 3000; n++) begin
            bit t, s, p, c, l, lp;
            if ($urandom_range(0, 99) < 5) rd = ~rd;
            t  = ($urandom_range(0, 99) < 60);
            s  = ($urandom_range(0, 99) < 15);
            p  = ($urandom_range(0, 99) < 5);
            c  = ($urandom_range(0, 99) < 3);
            l  = ($urandom_range(0, 99) < 5);
            lp = ($urandom_range(0, 99) < 8);
            cyc(t, s, p, c, l, 16'($urandom), rd, lp);
        end

        idle();
        @(negedge clk);
        cmp("queue_drained", 16'(q_exp.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
